// File: rtl/tx_seq_pkg.sv
// Shared definitions for the transmit byte sequencer: state encoding and checksum width.
// The optional checksum byte is enabled by defining TX_SEQ_CHECKSUM_EN.
package tx_seq_pkg;

    localparam logic [2:0] StateIdle    = 3'd0;
    localparam logic [2:0] StateFetch   = 3'd1;
    localparam logic [2:0] StateWaitMem = 3'd2;
    localparam logic [2:0] StateLoad    = 3'd3;
    localparam logic [2:0] StateWaitTx  = 3'd4;
    localparam logic [2:0] StateCksum   = 3'd5;
    localparam logic [2:0] StateDone    = 3'd6;

    typedef enum logic [2:0] {
        StIdle    = StateIdle,
        StFetch   = StateFetch,
        StWaitMem = StateWaitMem,
        StLoad    = StateLoad,
        StWaitTx  = StateWaitTx,
        StCksum   = StateCksum,
        StDone    = StateDone
    } tx_seq_state_e;

    localparam int unsigned CksumW = 8;

endpackage

// File: rtl/tx_seq_cksum.sv
// Modular 8-bit accumulator for the frame checksum; clear wins over add.
// Only instantiated when TX_SEQ_CHECKSUM_EN is defined.
module tx_seq_cksum
    import tx_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [CksumW-1:0] data_i,
    output logic [CksumW-1:0] sum_o
);

    logic [CksumW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/tx_byte_sequencer.sv
// Streams a block of bytes from memory into the byte transmitter, one load per byte.
// Define TX_SEQ_CHECKSUM_EN to append an 8-bit modular checksum byte to each non-empty frame.
module tx_byte_sequencer
    import tx_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_tx_i,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] length_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_wr_n_o,
    input  logic              tx_busy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        state_out_o,
    output logic [ADDR_W-1:0] byte_cnt_o
);

    tx_seq_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              tx_wr_n_q, tx_wr_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              start_acc;
    logic              load_fire;
    logic              payload_done;

    assign start_acc    = (state_q == StIdle) && start_i && !abort_i;
    // An abort in LOAD must not count the byte that was about to be loaded.
    assign load_fire    = (state_q == StLoad) && !abort_i;
    assign payload_done = (idx_q == len_q);

`ifdef TX_SEQ_CHECKSUM_EN
    logic              sent_q, sent_d;
    logic [CksumW-1:0] cksum;

    tx_seq_cksum u_cksum (
        .clk_i  (clk_tx_i),
        .rst_n  (rst_n),
        .clr_i  (start_acc),
        .add_i  (load_fire),
        .data_i (tx_data_q),
        .sum_o  (cksum)
    );

    always_comb begin
        sent_d = sent_q;
        if (start_acc) begin
            sent_d = 1'b0;
        end else if (state_d == StCksum) begin
            sent_d = 1'b1;
        end
    end

    always_ff @(posedge clk_tx_i or negedge rst_n) begin
        if (!rst_n) begin
            sent_q <= 1'b0;
        end else begin
            sent_q <= sent_d;
        end
    end
`endif

    always_ff @(posedge clk_tx_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d = (length_i == '0) ? StDone : StFetch;
                end
            end
            StFetch:   state_d = StWaitMem;
            StWaitMem: state_d = StLoad;
            StLoad:    state_d = StWaitTx;
            StWaitTx: begin
                if (!tx_busy_i) begin
                    if (!payload_done) begin
                        state_d = StFetch;
                    end else begin
`ifdef TX_SEQ_CHECKSUM_EN
                        state_d = sent_q ? StDone : StCksum;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            StCksum: state_d = StWaitTx;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        mem_rd_d   = (state_d == StFetch);
        tx_wr_n_d  = !((state_d == StLoad) || (state_d == StCksum));
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
        mem_addr_d = mem_addr_q;
        if (state_d == StFetch) begin
            mem_addr_d = start_acc ? base_addr_i : base_q + idx_q;
        end

        base_d = base_q;
        len_d  = len_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        if (start_acc) begin
            base_d = base_addr_i;
            len_d  = length_i;
            idx_d  = '0;
            cnt_d  = '0;
        end else if (load_fire) begin
            idx_d = idx_q + ADDR_W'(1);
            cnt_d = cnt_q + ADDR_W'(1);
        end

        tx_data_d = tx_data_q;
        if (state_q == StWaitMem) begin
            tx_data_d = mem_data_i;
        end
`ifdef TX_SEQ_CHECKSUM_EN
        if (state_d == StCksum) begin
            tx_data_d = cksum;
        end
`endif
    end

    always_ff @(posedge clk_tx_i or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            tx_wr_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            tx_wr_n_q  <= tx_wr_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign tx_data_o   = tx_data_q;
    assign tx_wr_n_o   = tx_wr_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_out_o = state_q;
    assign byte_cnt_o  = cnt_q;

endmodule

// File: tb/tb_tx_byte_sequencer.sv
// Scoreboard bench for tx_byte_sequencer: a frame-level model queues expected fetch addresses,
// transmitted bytes and completion counts; a negedge monitor pops and compares them.
module tb_tx_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, abort_i, tx_busy_i;
    logic [7:0] base_addr_i, length_i, mem_data_i;
    logic [7:0] mem_addr_o, tx_data_o, byte_cnt_o;
    logic       mem_rd_o, tx_wr_n_o, busy_o, done_o;
    logic [2:0] state_out_o;

    always #5 clk = ~clk;

    tx_byte_sequencer #(.ADDR_W(8)) dut (
        .clk_tx_i    (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .mem_addr_o  (mem_addr_o),
        .mem_rd_o    (mem_rd_o),
        .mem_data_i  (mem_data_i),
        .tx_data_o   (tx_data_o),
        .tx_wr_n_o   (tx_wr_n_o),
        .tx_busy_i   (tx_busy_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .state_out_o (state_out_o),
        .byte_cnt_o  (byte_cnt_o)
    );

    logic [7:0] mem [256];
    always @(posedge clk) if (mem_rd_o) mem_data_i <= mem[mem_addr_o];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int start_ref = 0;
    int busy_len  = 0;
    int busy_cnt  = 0;
    int pass_cnt  = 0;
    int chk_cnt   = 0;

    logic [7:0] exp_addr[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_done[$];
    int         strobe_log[$];
    int         done_log[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    task automatic unexpected(input string name);
        chk_cnt++;
        $display("FAIL %s: event seen with nothing expected (t=%0t)", name, $time);
    endtask

    task automatic chk_log(input string name, input int got[$], input int want[$]);
        chk({name, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            chk(name, (i < got.size()) ? got[i] : -1, want[i]);
    endtask

    // Transmitter model: busy for busy_len cycles after each load strobe.
    initial begin
        tx_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) busy_cnt = 0;
            else begin
                if (busy_cnt > 0) busy_cnt--;
                if (!tx_wr_n_o) busy_cnt = busy_len;
            end
            tx_busy_i = (busy_cnt > 0);
        end
    end

    // Monitor: every strobe, read and done is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!tx_wr_n_o) begin
                    strobe_log.push_back(cyc - start_ref);
                    if (exp_tx.size() == 0) unexpected("tx_strobe");
                    else chk("tx_data", tx_data_o, exp_tx.pop_front());
                end
                if (mem_rd_o) begin
                    if (exp_addr.size() == 0) unexpected("mem_rd");
                    else chk("mem_addr", mem_addr_o, exp_addr.pop_front());
                end
                if (done_o) begin
                    done_log.push_back(cyc - start_ref);
                    if (exp_done.size() == 0) unexpected("done");
                    else chk("done_byte_cnt", byte_cnt_o, exp_done.pop_front());
                end
            end
        end
    end

    task automatic expect_frame(input logic [7:0] base, input logic [7:0] len);
        logic [7:0] sum;
        logic [7:0] a;
        sum = 8'h00;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 8'(i);
            exp_addr.push_back(a);
            exp_tx.push_back(mem[a]);
            sum = sum + mem[a];
        end
`ifdef TX_SEQ_CHECKSUM_EN
        if (len != 8'd0) exp_tx.push_back(sum);
`endif
        exp_done.push_back(len);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_rd"}, mem_rd_o, 0);
        chk({tag, "_tx_data"}, tx_data_o, 0);
        chk({tag, "_tx_wr_n"}, tx_wr_n_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_state"}, state_out_o, 0);
        chk({tag, "_byte_cnt"}, byte_cnt_o, 0);
    endtask

    // Called at a negedge; optionally pulses a stray start at relative cycle glitch_at.
    task automatic run_frame(input logic [7:0] base, input logic [7:0] len, input int bl,
                             input int glitch_at);
        int n;
        expect_frame(base, len);
        busy_len = bl;
        strobe_log.delete();
        done_log.delete();
        start_ref   = cyc;
        base_addr_i = base;
        length_i    = len;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (busy_o === 1'b1 && n < 3000) begin
            if (glitch_at > 0 && cyc - start_ref == glitch_at) begin
                start_i     = 1'b1;
                base_addr_i = 8'($urandom);
                length_i    = 8'd5;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        chk("frame_finished", busy_o, 0);
        chk("sb_tx_drained", exp_tx.size(), 0);
        chk("sb_addr_drained", exp_addr.size(), 0);
        chk("sb_done_drained", exp_done.size(), 0);
    endtask

    int none[$];

    initial begin
        int n;
        logic [7:0] b, l;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        base_addr_i = 8'h00; length_i = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Reference frame, transmitter always idle.
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'h55; mem[8'h12] = 8'h0F;
        run_frame(8'h10, 8'd3, 0, 0);
`ifdef TX_SEQ_CHECKSUM_EN
        chk_log("strobe_cycle", strobe_log, '{3, 7, 11, 13});
        chk_log("done_cycle", done_log, '{15});
        chk("tx_data_hold", tx_data_o, 8'h0E);
`else
        chk_log("strobe_cycle", strobe_log, '{3, 7, 11});
        chk_log("done_cycle", done_log, '{13});
        chk("tx_data_hold", tx_data_o, 8'h0F);
`endif
        chk("byte_cnt_hold", byte_cnt_o, 3);

        // Busy transmitter stretches each byte; a start mid-frame must be ignored.
        run_frame(8'h10, 8'd3, 5, 5);
`ifdef TX_SEQ_CHECKSUM_EN
        chk_log("busy_strobe_cycle", strobe_log, '{3, 11, 19, 25});
        chk_log("busy_done_cycle", done_log, '{31});
`else
        chk_log("busy_strobe_cycle", strobe_log, '{3, 11, 19});
        chk_log("busy_done_cycle", done_log, '{25});
`endif
        chk("busy_byte_cnt", byte_cnt_o, 3);

        run_frame(8'hFE, 8'd4, 1, 0);
        chk("wrap_byte_cnt", byte_cnt_o, 4);

        run_frame(8'h33, 8'd0, 0, 0);
        chk_log("len0_strobe", strobe_log, none);
        chk_log("len0_done_cycle", done_log, '{1});

        // start and abort together in IDLE
        start_i = 1'b1; abort_i = 1'b1; length_i = 8'd3;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_abort_state", state_out_o, 0);
        chk("start_abort_busy", busy_o, 0);
        chk("start_abort_rd", mem_rd_o, 0);

        // Abort in the cycle that would enter the second LOAD.
        exp_addr.push_back(8'h40); exp_addr.push_back(8'h41);
        exp_tx.push_back(mem[8'h40]);
        strobe_log.delete(); done_log.delete();
        busy_len = 0;
        start_ref = cyc; base_addr_i = 8'h40; length_i = 8'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (cyc - start_ref < 6 && n < 20) begin @(negedge clk); n++; end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_state", state_out_o, 0);
        chk("abort_tx_wr_n", tx_wr_n_o, 1);
        chk("abort_byte_cnt", byte_cnt_o, 1);
        chk("abort_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        chk_log("abort_strobe", strobe_log, '{3});
        chk_log("abort_done", done_log, none);
        chk("abort_sb_tx", exp_tx.size(), 0);
        chk("abort_sb_addr", exp_addr.size(), 0);

        // Reset asserted while waiting on the transmitter.
        expect_frame(8'h80, 8'd4);
        busy_len = 5;
        start_ref = cyc; base_addr_i = 8'h80; length_i = 8'd4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (state_out_o !== 3'd4 && n < 50) begin @(negedge clk); n++; end
        chk("reached_wait_tx", state_out_o, 4);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_addr.delete(); exp_tx.delete(); exp_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_state", state_out_o, 0);
        run_frame(8'h80, 8'd4, 0, 0);
        chk("post_reset_byte_cnt", byte_cnt_o, 4);

        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            l = 8'($urandom_range(0, 6));
            run_frame(b, l, int'($urandom_range(0, 3)), 0);
            chk("rand_byte_cnt", byte_cnt_o, {24'd0, l});
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
